// File: rtl/float_point_multiplier.sv
// -----------------------------------------------------------------------------
// float_point_multiplier
//
// Sequential floating-point multiplier for the multiply-accumulate datapath.
// It feeds float_point_adder, so its result packing and finite-only treatment
// of the all-ones exponent match what the adder expects. The mantissa product
// is built by a radix-2 shift-add loop that handles one multiplier bit per
// cycle.
//
// Optional feature macro: FP_MUL_ROUND_NEAREST_EN
//   defined   -> round-to-nearest-even using the guard bit and a sticky bit
//   undefined -> truncation, which is how the adder treats dropped bits
//   Latency is the same in both builds.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset; aborts any operation
//   a, b            operands, packed {sign, exponent, fraction}
//   inp_data_ready  operands valid; looked at only while idle
//   product         registered result, held until the next result
//   prod_ready      one-cycle pulse in the cycle that product updates
//   busy            high while an operation is in flight
// -----------------------------------------------------------------------------
module float_point_multiplier #(
  parameter int EXP_LEN      = 8,
  parameter int MANTISSA_LEN = 23
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [EXP_LEN+MANTISSA_LEN:0]   a,
  input  logic [EXP_LEN+MANTISSA_LEN:0]   b,
  input  logic                            inp_data_ready,
  output logic [EXP_LEN+MANTISSA_LEN:0]   product,
  output logic                            prod_ready,
  output logic                            busy
);

  localparam int W     = EXP_LEN + MANTISSA_LEN + 1;
  localparam int M     = MANTISSA_LEN + 1;        // mantissa width including the hidden 1
  localparam int ACC_W = 2 * M;
  localparam int EW    = EXP_LEN + 2;             // signed working exponent width
  localparam int CNT_W = $clog2(M + 1);

  localparam int BIAS    = (2 ** (EXP_LEN - 1)) - 1;
  localparam int MAX_EXP = (2 ** EXP_LEN) - 1;
  localparam int M_LAST  = M - 1;

  localparam logic signed [EW-1:0] BIAS_S    = BIAS[EW-1:0];
  localparam logic signed [EW-1:0] MAX_EXP_S = MAX_EXP[EW-1:0];
  localparam logic signed [EW-1:0] ONE_S     = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]     CNT_LAST  = M_LAST[CNT_W-1:0];

`ifdef FP_MUL_ROUND_NEAREST_EN
  localparam logic RNE_EN = 1'b1;
`else
  localparam logic RNE_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    MUL   = 3'd2,
    NORM  = 3'd3,
    PACK  = 3'd4
  } state_t;

  state_t state_r, state_s;

  logic                 sign_r;
  logic [EXP_LEN-1:0]   ea_r, eb_r;
  logic [M-1:0]         ma_r, mb_r;
  logic signed [EW-1:0] exp_r;
  logic [ACC_W-1:0]     acc_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [M-1:0]         mant_r;
  logic                 guard_r, sticky_r;
  logic                 zero_r;
  logic [W-1:0]         product_r;
  logic                 prod_ready_r;
  logic                 busy_r;

  logic                 zero_s;
  logic [ACC_W-1:0]     addend_s;
  logic [M-1:0]         mant_n_s;
  logic                 guard_n_s, sticky_n_s;
  logic                 round_up_s;
  logic [M:0]           mant_rnd_s;
  logic [M-2:0]         frac_fin_s;
  logic signed [EW-1:0] exp_fin_s;
  logic [W-1:0]         result_s;

  assign product    = product_r;
  assign prod_ready = prod_ready_r;
  assign busy       = busy_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; CHECK branches on the zero-operand test
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (inp_data_ready) begin
          state_s = CHECK;
        end else begin
          state_s = IDLE;
        end
      end
      CHECK: begin
        if (zero_s) begin
          state_s = PACK;
        end else begin
          state_s = MUL;
        end
      end
      MUL: begin
        if (cnt_r == CNT_LAST) begin
          state_s = NORM;
        end else begin
          state_s = MUL;
        end
      end
      NORM:    state_s = PACK;
      PACK:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Zero-operand test and the shifted partial product for the current bit
  always_comb begin
    zero_s   = (ea_r == {EXP_LEN{1'b0}}) || (eb_r == {EXP_LEN{1'b0}});
    addend_s = {ACC_W{1'b0}};
    if (mb_r[cnt_r]) begin
      addend_s = {{M{1'b0}}, ma_r} << cnt_r;
    end else begin
      addend_s = {ACC_W{1'b0}};
    end
  end

  // Normalisation select: a set MSB means the product lies in [2,4)
  always_comb begin
    mant_n_s   = {M{1'b0}};
    guard_n_s  = 1'b0;
    sticky_n_s = 1'b0;
    if (acc_r[ACC_W-1]) begin
      mant_n_s   = acc_r[ACC_W-1:M];
      guard_n_s  = acc_r[M-1];
      sticky_n_s = |acc_r[M-2:0];
    end else begin
      mant_n_s   = acc_r[ACC_W-2:M-1];
      guard_n_s  = acc_r[M-2];
      sticky_n_s = |acc_r[M-3:0];
    end
  end

  // Rounding, renormalisation on carry-out, and range handling
  always_comb begin
    round_up_s = RNE_EN & guard_r & (sticky_r | mant_r[0]);
    mant_rnd_s = {1'b0, mant_r} + {{M{1'b0}}, round_up_s};
    frac_fin_s = {(M-1){1'b0}};
    exp_fin_s  = exp_r;
    result_s   = {W{1'b0}};
    // Carry out only happens from all-ones, so the shifted fraction is zero
    if (mant_rnd_s[M]) begin
      frac_fin_s = mant_rnd_s[M-1:1];
      exp_fin_s  = exp_r + ONE_S;
    end else begin
      frac_fin_s = mant_rnd_s[M-2:0];
      exp_fin_s  = exp_r;
    end
    if (zero_r) begin
      result_s = {W{1'b0}};
    end else if (exp_fin_s[EW-1] || (exp_fin_s == {EW{1'b0}})) begin
      result_s = {W{1'b0}};
    end else if (exp_fin_s > MAX_EXP_S) begin
      result_s = {sign_r, {EXP_LEN{1'b1}}, {MANTISSA_LEN{1'b1}}};
    end else begin
      result_s = {sign_r, exp_fin_s[EXP_LEN-1:0], frac_fin_s};
    end
  end

  // Datapath and output registers, stepped by the current state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r       <= 1'b0;
      ea_r         <= {EXP_LEN{1'b0}};
      eb_r         <= {EXP_LEN{1'b0}};
      ma_r         <= {M{1'b0}};
      mb_r         <= {M{1'b0}};
      exp_r        <= {EW{1'b0}};
      acc_r        <= {ACC_W{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      mant_r       <= {M{1'b0}};
      guard_r      <= 1'b0;
      sticky_r     <= 1'b0;
      zero_r       <= 1'b0;
      product_r    <= {W{1'b0}};
      prod_ready_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          prod_ready_r <= 1'b0;
          if (inp_data_ready) begin
            sign_r <= a[W-1] ^ b[W-1];
            ea_r   <= a[W-2:MANTISSA_LEN];
            eb_r   <= b[W-2:MANTISSA_LEN];
            ma_r   <= {1'b1, a[MANTISSA_LEN-1:0]};
            mb_r   <= {1'b1, b[MANTISSA_LEN-1:0]};
            busy_r <= 1'b1;
          end
        end
        CHECK: begin
          zero_r <= zero_s;
          exp_r  <= $signed({2'b00, ea_r}) + $signed({2'b00, eb_r}) - BIAS_S;
          acc_r  <= {ACC_W{1'b0}};
          cnt_r  <= {CNT_W{1'b0}};
        end
        MUL: begin
          acc_r <= acc_r + addend_s;
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        NORM: begin
          mant_r   <= mant_n_s;
          guard_r  <= guard_n_s;
          sticky_r <= sticky_n_s;
          if (acc_r[ACC_W-1]) begin
            exp_r <= exp_r + ONE_S;
          end
        end
        PACK: begin
          product_r    <= result_s;
          prod_ready_r <= 1'b1;
          busy_r       <= 1'b0;
        end
        default: begin
          prod_ready_r <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

endmodule
